// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU share arbiter.
// Optional feature macro: ALU_ARB_SR_PER_REQ_EN (one status register per requester).
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // EXE_CMD encodings understood by the external ALU
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   // Bit positions inside a {N,Z,C,V} status nibble
   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester/response bus of the ALU share arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_val1;
   logic [NUM_REQ*DATA_W-1:0] req_val2;
   logic [NUM_REQ*4-1:0]      req_cmd;
   logic [NUM_REQ-1:0]        req_s;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [IDW-1:0]            rsp_id;
   logic [DATA_W-1:0]         rsp_result;
   logic [3:0]                rsp_status;

   modport master (
      output req_valid, req_val1, req_val2, req_cmd, req_s, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_status
   );

   modport slave (
      input  req_valid, req_val1, req_val2, req_cmd, req_s, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_status
   );
endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Round-robin grant search: first set request bit after ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   // Walk ptr+1 .. ptr+N (mod N); the first requester found wins
   always_comb begin
      logic w_found;
      int   w_cand;
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = 0;
      for (int i = 1; i <= N; i++) begin
         w_cand = (int'(i_ptr) + i) % N;
         if (!w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = IW'(w_cand);
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// Sequence per op: IDLE (grant + capture) -> ISSUE (drive ALU, capture) -> RESP.
// Optional feature macro: ALU_ARB_SR_PER_REQ_EN -- one {N,Z,C,V} register per
// requester; otherwise a single status register shared by all requesters.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_arbiter_if.slave bus,
   output logic [DATA_W-1:0] o_alu_val1,
   output logic [DATA_W-1:0] o_alu_val2,
   output logic [3:0]        o_alu_cmd,
   output logic [3:0]        o_alu_sr,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic [3:0]        i_alu_status
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              r_state;
   logic [IW-1:0]       r_ptr;
   logic [DATA_W-1:0]   r_val1, r_val2;
   logic [3:0]          r_cmd;
   logic                r_s;
   logic [IW-1:0]       r_id;
   logic                r_rsp_valid;
   logic [IW-1:0]       r_rsp_id;
   logic [DATA_W-1:0]   r_rsp_result;
   logic [3:0]          r_rsp_status;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [IW-1:0]       w_gidx;
   logic [3:0]          w_sr_cur;

`ifdef ALU_ARB_SR_PER_REQ_EN
   logic [NUM_REQ-1:0][3:0] r_sr;
   assign w_sr_cur = r_sr[r_id];
`else
   logic [3:0] r_sr;
   assign w_sr_cur = r_sr;
`endif

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .i_req (bus.req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gidx)
   );

   // Accept pulse only while idle; the requester drops its request on seeing it
   assign bus.req_ready  = (r_state == IDLE) ? w_gnt : '0;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_status = r_rsp_status;

   // ALU sees the captured operands only during ISSUE, zeros otherwise
   always_comb begin
      o_alu_val1 = '0;
      o_alu_val2 = '0;
      o_alu_cmd  = '0;
      o_alu_sr   = '0;
      if (r_state == ISSUE) begin
         o_alu_val1 = r_val1;
         o_alu_val2 = r_val2;
         o_alu_cmd  = r_cmd;
         o_alu_sr   = w_sr_cur;
      end
   end

   // Control FSM with operand capture, response registers and status update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ptr        <= IW'(NUM_REQ - 1);
         r_val1       <= '0;
         r_val2       <= '0;
         r_cmd        <= '0;
         r_s          <= 1'b0;
         r_id         <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_rsp_status <= '0;
         r_sr         <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|bus.req_valid) begin
                  r_val1  <= bus.req_val1[w_gidx*DATA_W +: DATA_W];
                  r_val2  <= bus.req_val2[w_gidx*DATA_W +: DATA_W];
                  r_cmd   <= bus.req_cmd[w_gidx*4 +: 4];
                  r_s     <= bus.req_s[w_gidx];
                  r_id    <= w_gidx;
                  r_ptr   <= w_gidx;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_rsp_result <= i_alu_result;
               r_rsp_status <= i_alu_status;
               r_rsp_id     <= r_id;
               r_rsp_valid  <= 1'b1;
               if (r_s) begin
`ifdef ALU_ARB_SR_PER_REQ_EN
                  r_sr[r_id] <= i_alu_status;
`else
                  r_sr <= i_alu_status;
`endif
               end
               r_state <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
